// File: rtl/csa_byte_serial_ctrl_if.sv
// rtl/csa_byte_serial_ctrl_if.sv - operand, adder and result bundle for csa_byte_serial_ctrl (res_ovf present with CSA_SIGNED_OVF_EN)
interface csa_byte_serial_ctrl_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;

  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic [7:0]   add_sum;
  logic         add_cout;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;

`ifdef CSA_SIGNED_OVF_EN
  logic         res_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, add_sum, add_cout, res_ready,
    input  in_ready, add_a, add_b, add_cin, res_valid, res_sum, res_cout, res_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, res_ready,
    output in_ready, add_a, add_b, add_cin, res_valid, res_sum, res_cout, res_ovf
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_cin, add_sum, add_cout, res_ready,
    input  in_ready, add_a, add_b, add_cin, res_valid, res_sum, res_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, res_ready,
    output in_ready, add_a, add_b, add_cin, res_valid, res_sum, res_cout
  );
`endif

endinterface

// File: rtl/csa_byte_serial_ctrl.sv
// rtl/csa_byte_serial_ctrl.sv - byte-serial sequencer around an 8-bit carry-skip adder; CSA_SIGNED_OVF_EN adds res_ovf
module csa_byte_serial_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  csa_byte_serial_ctrl_if.slave bus
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          carry_q;
  logic          cout_q;
  logic          rdy_q;
  logic [IW-1:0] idx_q;
  logic          last;
  logic          run;

  assign run  = (state == RUN);
  assign last = (idx_q == IW'(NBYTES - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last)          state_nxt = DONE;
      DONE:    if (bus.res_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Adder operands come only from registers, so no input reaches the adder combinationally.
  assign bus.add_a     = run ? a_q[{idx_q, 3'b000} +: 8] : 8'd0;
  assign bus.add_b     = run ? b_q[{idx_q, 3'b000} +: 8] : 8'd0;
  assign bus.add_cin   = run ? carry_q : 1'b0;
  assign bus.in_ready  = rdy_q;
  assign bus.res_valid = (state == DONE);
  assign bus.res_sum   = sum_q;
  assign bus.res_cout  = cout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      rdy_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt == IDLE);
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            carry_q <= bus.in_cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q[{idx_q, 3'b000} +: 8] <= bus.add_sum;
          carry_q                     <= bus.add_cout;
          idx_q                       <= idx_q + IW'(1);
          if (last) cout_q <= bus.add_cout;
        end
        default: ;
      endcase
    end
  end

`ifdef CSA_SIGNED_OVF_EN
  logic ovf_q;

  assign bus.res_ovf = ovf_q;

  // The top byte's sum bit 7 is the final sign bit of the full-width result.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (run && last) begin
      ovf_q <= (a_q[W-1] == b_q[W-1]) && (bus.add_sum[7] != a_q[W-1]);
    end
  end
`endif

endmodule

// File: tb/tb_csa_byte_serial_ctrl.sv
// tb/tb_csa_byte_serial_ctrl.sv - scoreboard bench for csa_byte_serial_ctrl (honours CSA_SIGNED_OVF_EN)
`timescale 1ns/1ps
module tb_csa_byte_serial_ctrl;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  typedef struct packed {
    logic [W-1:0]      sum;
    logic              cout;
    logic              ovf;
    logic [NBYTES-1:0] cins;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csa_byte_serial_ctrl_if #(.NBYTES(NBYTES)) bus ();

  csa_byte_serial_ctrl #(.NBYTES(NBYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural stand-in for the 8-bit carry-skip adder.
  always_comb {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {8'd0, bus.add_cin};

  exp_t              exp_q[$];
  int                errors = 0;
  int                checks = 0;
  logic [W-1:0]      got_sum;
  logic              got_cout;
  logic              got_ovf;
  logic [NBYTES-1:0] got_cins;
  int                got_edges;
  int                got_ncin;
  time               last_accept;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    exp_t         e;
    logic [W:0]   s;
    logic [W:0]   m;
    logic [W:0]   t;
    s      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.sum  = s[W-1:0];
    e.cout = s[W];
    e.ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    for (int k = 0; k < NBYTES; k++) begin
      m         = ({{W{1'b0}}, 1'b1} << (8 * k)) - 1'b1;
      t         = ({1'b0, a} & m) + ({1'b0, b} & m) + {{W{1'b0}}, cin};
      e.cins[k] = t[8 * k];
    end
    return e;
  endfunction

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input bit push, output bit ok);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok          = bus.in_ready;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    last_accept  = $time;
    if (ok && push) exp_q.push_back(model(a, b, cin));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic get_result(output bit ok);
    got_edges = 1;
    got_ncin  = 0;
    got_cins  = '0;
    while (!bus.res_valid && got_edges < 40) begin
      if (got_ncin < NBYTES) got_cins[got_ncin] = bus.add_cin;
      got_ncin++;
      @(negedge clk);
      got_edges++;
    end
    ok       = bus.res_valid;
    got_sum  = bus.res_sum;
    got_cout = bus.res_cout;
`ifdef CSA_SIGNED_OVF_EN
    got_ovf  = bus.res_ovf;
`else
    got_ovf  = 1'b0;
`endif
    if (ok) begin
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_sum !== '0 || bus.res_cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: in_ready=%b res_valid=%b res_sum=%h res_cout=%b, required 0 0 0 0",
               bus.in_ready, bus.res_valid, bus.res_sum, bus.res_cout);
    end
    checks++;
    if ({bus.add_a, bus.add_b, bus.add_cin} !== 17'd0) begin
      errors++;
      $display("FAIL reset_adder: add_a=%h add_b=%h add_cin=%b, required 0", bus.add_a, bus.add_b, bus.add_cin);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va[10];
    logic [W-1:0] vb[10];
    logic         vc[10];
    bit           ok;
    exp_t         e;
    va[0] = 32'h0000_0001; vb[0] = 32'h0000_0001; vc[0] = 1'b0;
    va[1] = 32'h00FF_FFFF; vb[1] = 32'h0000_0001; vc[1] = 1'b0;
    va[2] = 32'hFFFF_FFFF; vb[2] = 32'h0000_0000; vc[2] = 1'b1;
    va[3] = 32'h7FFF_FFFF; vb[3] = 32'h0000_0001; vc[3] = 1'b0;
    for (int i = 4; i < 10; i++) begin
      va[i] = $urandom();
      vb[i] = $urandom();
      vc[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 10; i++) begin
      drive_op(va[i], vb[i], vc[i], 1'b1, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL vec%0d_accept: in_ready never rose, required accept", i);
        continue;
      end
      get_result(ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || got_edges != NBYTES + 1) begin
        errors++;
        $display("FAIL vec%0d_latency: valid=%b after %0d edges, required %0d", i, ok, got_edges, NBYTES + 1);
      end
      checks++;
      if (got_sum !== e.sum || got_cout !== e.cout) begin
        errors++;
        $display("FAIL vec%0d_sum: res_sum=%h res_cout=%b, required %h %b", i, got_sum, got_cout, e.sum, e.cout);
      end
      checks++;
      if (got_ncin != NBYTES || got_cins !== e.cins) begin
        errors++;
        $display("FAIL vec%0d_add_cin: %0d cycles seq=%b, required %0d cycles seq=%b",
                 i, got_ncin, got_cins, NBYTES, e.cins);
      end
`ifdef CSA_SIGNED_OVF_EN
      checks++;
      if (got_ovf !== e.ovf) begin
        errors++;
        $display("FAIL vec%0d_ovf: res_ovf=%b, required %b", i, got_ovf, e.ovf);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    bit   ok;
    exp_t e;
    time  prev;
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      drive_op(32'h0101_0101 * (i + 1), 32'hF0F0_F0F0, 1'(i), 1'b1, ok);
      if (i > 0) begin
        checks++;
        if (!ok || last_accept - prev != 10 * (NBYTES + 2)) begin
          errors++;
          $display("FAIL b2b_interval%0d: %0t between accepts, required %0t", i, last_accept - prev,
                   time'(10 * (NBYTES + 2)));
        end
      end
      prev = last_accept;
      get_result(ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || got_sum !== e.sum || got_cout !== e.cout) begin
        errors++;
        $display("FAIL b2b_sum%0d: valid=%b res_sum=%h res_cout=%b, required %h %b",
                 i, ok, got_sum, got_cout, e.sum, e.cout);
      end
    end
  endtask

  task automatic test_backpressure();
    bit   ok;
    int   n;
    exp_t e;
    drive_op(32'h89AB_CDEF, 32'h1234_5678, 1'b0, 1'b1, ok);
    n = 0;
    while (!bus.res_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.res_valid) begin
      errors++;
      $display("FAIL bp_valid: res_valid=%b, required 1", bus.res_valid);
    end
    e = exp_q.pop_front();
    bus.in_valid = 1'b1;
    bus.in_a     = 32'hDEAD_BEEF;
    bus.in_b     = 32'h0000_1111;
    bus.in_cin   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.res_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.res_sum !== e.sum || bus.res_cout !== e.cout) begin
        errors++;
        $display("FAIL bp_hold%0d: res_valid=%b in_ready=%b res_sum=%h res_cout=%b, required 1 0 %h %b",
                 i, bus.res_valid, bus.in_ready, bus.res_sum, bus.res_cout, e.sum, e.cout);
      end
      checks++;
      if ({bus.add_a, bus.add_b, bus.add_cin} !== 17'd0) begin
        errors++;
        $display("FAIL bp_adder_idle%0d: add_a=%h add_b=%h add_cin=%b, required 0", i, bus.add_a, bus.add_b, bus.add_cin);
      end
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle: in_ready=%b res_valid=%b, required 1 0", bus.in_ready, bus.res_valid);
    end
    exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_cin));
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: in_ready=%b, required 0", bus.in_ready);
    end
    get_result(ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || got_sum !== e.sum || got_cout !== e.cout) begin
      errors++;
      $display("FAIL bp_next_sum: valid=%b res_sum=%h res_cout=%b, required %h %b", ok, got_sum, got_cout, e.sum, e.cout);
    end
  endtask

  task automatic test_rst_mid();
    bit   ok;
    bit   seen;
    exp_t e;
    drive_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, ok);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_sum !== '0 || bus.res_cout !== 1'b0 ||
        {bus.add_a, bus.add_b, bus.add_cin} !== 17'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: in_ready=%b res_valid=%b res_sum=%h res_cout=%b add=%h/%h/%b, required all 0",
               bus.in_ready, bus.res_valid, bus.res_sum, bus.res_cout, bus.add_a, bus.add_b, bus.add_cin);
    end
    rst  = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_mid_no_result: res_valid asserted=%b, required 0", seen);
    end
    drive_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, ok);
    get_result(ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || got_sum !== 32'h2345_6789 || got_sum !== e.sum || got_cout !== e.cout) begin
      errors++;
      $display("FAIL rst_mid_rerun: valid=%b res_sum=%h res_cout=%b, required %h %b", ok, got_sum, got_cout, e.sum, e.cout);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded, required completion", $time);
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.res_ready = 1'b0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_rst_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
